// File: rtl/data_memory_be.sv
// data_memory_be: byte-addressed MEM-stage data memory with lane-enabled
// stores, sign/zero-extending loads, registered read data with a ReadValid
// strobe, misalignment detection and a clear sweep after reset.
// Optional build macro: DATA_MEMORY_BE_FORWARD_EN makes a simultaneous
// load and store to the same word return the post-store merged word
// instead of the pre-store contents.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_CLEAR | zeroing word clear_idx_q each cycle; Busy=1, requests dropped
// ST_READY | serving loads and stores
module data_memory_be #(
    parameter  int DATA_WIDTH  = 32,
    parameter  int DEPTH_WORDS = 64,
    localparam int ADDR_WIDTH  = $clog2(DEPTH_WORDS * DATA_WIDTH / 8)
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  MemoryRead,
    input  logic                  MemoryWrite,
    input  logic [1:0]            Size,
    input  logic                  Unsigned,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  ReadValid,
    output logic                  Misaligned,
    output logic                  Busy
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = ADDR_WIDTH - OFF_W;

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];
    state_t                state_q;
    logic [IDX_W-1:0]      clear_idx_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  valid_q;
    logic                  mis_q;
    logic                  busy_q;

    logic [OFF_W-1:0]      offset;
    logic [IDX_W-1:0]      widx;
    logic [OFF_W+2:0]      bit_sh;
    logic                  mis_d;
    logic [NB-1:0]         base_be;
    logic [NB-1:0]         lane_be;
    logic [DATA_WIDTH-1:0] wdata_sh;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] merged_d;
    logic [DATA_WIDTH-1:0] load_src;
    logic [DATA_WIDTH-1:0] rd_sh;
    logic [DATA_WIDTH-1:0] load_d;
    logic                  sign_bit;
    int                    ext_w;

    assign offset   = Address[OFF_W-1:0];
    assign widx     = Address[ADDR_WIDTH-1:OFF_W];
    assign bit_sh   = {offset, 3'b000};
    assign old_word = mem_q[widx];
    assign wdata_sh = WriteData << bit_sh;
    assign lane_be  = base_be << offset;

    // Alignment check and base lane mask per access size
    always_comb begin
        mis_d   = 1'b0;
        base_be = '1;
        unique case (Size)
            2'b00: begin
                mis_d   = 1'b0;
                base_be = NB'(1);
            end
            2'b01: begin
                mis_d   = Address[0];
                base_be = NB'(3);
            end
            2'b10: begin
                mis_d   = (Address[1:0] != 2'b00);
                base_be = NB'(15);
            end
            default: begin
                // A dword cannot exist on a 32-bit memory
                mis_d   = (DATA_WIDTH == 32) ? 1'b1 : (Address[2:0] != 3'b000);
                base_be = '1;
            end
        endcase
    end

    // Store merge: enabled lanes take shifted store data, others keep old bytes
    always_comb begin
        merged_d = old_word;
        for (int k = 0; k < NB; k++) begin
            if (lane_be[k]) merged_d[8*k +: 8] = wdata_sh[8*k +: 8];
        end
    end

    // Load path: pick source word, right-justify, then sign/zero extend
    always_comb begin
`ifdef DATA_MEMORY_BE_FORWARD_EN
        load_src = MemoryWrite ? merged_d : old_word;
`else
        load_src = old_word;
`endif
        rd_sh    = load_src >> bit_sh;
        ext_w    = DATA_WIDTH;
        sign_bit = rd_sh[DATA_WIDTH-1];
        unique case (Size)
            2'b00:   begin ext_w = 8;  sign_bit = rd_sh[7];  end
            2'b01:   begin ext_w = 16; sign_bit = rd_sh[15]; end
            2'b10:   begin ext_w = 32; sign_bit = rd_sh[31]; end
            default: begin ext_w = DATA_WIDTH; sign_bit = rd_sh[DATA_WIDTH-1]; end
        endcase
        load_d = rd_sh;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i >= ext_w) load_d[i] = sign_bit & ~Unsigned;
        end
    end

    // Control FSM with registered outputs
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q     <= ST_CLEAR;
            clear_idx_q <= '0;
            busy_q      <= 1'b1;
            rdata_q     <= '0;
            valid_q     <= 1'b0;
            mis_q       <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            case (state_q)
                ST_CLEAR: begin
                    clear_idx_q <= clear_idx_q + IDX_W'(1);
                    if (clear_idx_q == IDX_W'(DEPTH_WORDS - 1)) begin
                        state_q <= ST_READY;
                        busy_q  <= 1'b0;
                    end
                end
                ST_READY: begin
                    if (MemoryRead || MemoryWrite) begin
                        if (mis_d) begin
                            mis_q <= 1'b1;
                        end else if (MemoryRead) begin
                            valid_q <= 1'b1;
                            rdata_q <= load_d;
                        end
                    end
                end
                default: state_q <= ST_CLEAR;
            endcase
        end
    end

    // Array writes: clear sweep owns the array until READY
    always_ff @(posedge Clock) begin
        if (Reset_n) begin
            if (state_q == ST_CLEAR) begin
                mem_q[clear_idx_q] <= '0;
            end else if (MemoryWrite && !mis_d) begin
                mem_q[widx] <= merged_d;
            end
        end
    end

    assign ReadData   = rdata_q;
    assign ReadValid  = valid_q;
    assign Misaligned = mis_q;
    assign Busy       = busy_q;

endmodule

// File: tb/tb_data_memory_be.sv
// Directed bench for data_memory_be (DATA_WIDTH=32, DEPTH_WORDS=64).
module tb_data_memory_be;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic [7:0]  Address = '0;
    logic [31:0] WriteData = '0;
    logic        MemoryRead = 1'b0;
    logic        MemoryWrite = 1'b0;
    logic [1:0]  Size = 2'b10;
    logic        Unsigned = 1'b0;
    logic [31:0] ReadData;
    logic        ReadValid;
    logic        Misaligned;
    logic        Busy;

    int errors = 0;
    int checks = 0;

    data_memory_be #(.DATA_WIDTH(32), .DEPTH_WORDS(64)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Address(Address), .WriteData(WriteData),
        .MemoryRead(MemoryRead), .MemoryWrite(MemoryWrite), .Size(Size),
        .Unsigned(Unsigned), .ReadData(ReadData), .ReadValid(ReadValid),
        .Misaligned(Misaligned), .Busy(Busy)
    );

    always #5 Clock = ~Clock;

`ifdef DATA_MEMORY_BE_FORWARD_EN
    localparam logic [31:0] FWD_W = 32'hCAFEF00D;
    localparam logic [31:0] FWD_B = 32'h000000AB;
`else
    localparam logic [31:0] FWD_W = 32'h12345678;
    localparam logic [31:0] FWD_B = 32'h000000F0;
`endif

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        exp_v;
        logic        exp_m;
        logic [31:0] exp_d;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rd, logic wr, logic [1:0] size, logic uns,
                                logic [7:0] addr, logic [31:0] wdata,
                                logic exp_v, logic exp_m, logic [31:0] exp_d);
        vec_t v;
        v.rd = rd; v.wr = wr; v.size = size; v.uns = uns; v.addr = addr;
        v.wdata = wdata; v.exp_v = exp_v; v.exp_m = exp_m; v.exp_d = exp_d;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        MemoryRead = 1'b0; MemoryWrite = 1'b0; Size = 2'b10; Unsigned = 1'b0;
        Address = '0; WriteData = '0;
    endtask

    // Counts Busy-high samples starting at the negedge right after reset release.
    // With drop_check set, every busy cycle must show no ReadValid/Misaligned.
    task automatic count_busy(input string name, input bit drop_check);
        int n = 0;
        while (Busy === 1'b1 && n < 200) begin
            if (drop_check) begin
                check({name, " drop valid"}, {31'b0, ReadValid}, 32'd0);
                check({name, " drop mis"}, {31'b0, Misaligned}, 32'd0);
            end
            n++;
            @(negedge Clock);
        end
        check({name, " busy cycles"}, n, 64);
    endtask

    initial begin
        // Reset and sweep
        Reset_n = 1'b0;
        repeat (2) @(negedge Clock);
        Reset_n = 1'b1;
        check("rst ReadData", ReadData, 32'd0);
        check("rst ReadValid", {31'b0, ReadValid}, 32'd0);
        check("rst Misaligned", {31'b0, Misaligned}, 32'd0);
        check("rst Busy", {31'b0, Busy}, 32'd1);
        count_busy("sweep1", 1'b0);

        //                rd wr size  uns addr   wdata          v  m  data
        vecs.push_back(mk(1, 0, 2'b10, 0, 8'h00, 32'h0,         1, 0, 32'h00000000));
        vecs.push_back(mk(1, 0, 2'b10, 0, 8'h7C, 32'h0,         1, 0, 32'h00000000));
        vecs.push_back(mk(1, 0, 2'b10, 0, 8'hFC, 32'h0,         1, 0, 32'h00000000));
        vecs.push_back(mk(0, 1, 2'b10, 0, 8'h10, 32'hDEADBEEF,  0, 0, 32'h00000000));
        vecs.push_back(mk(0, 1, 2'b00, 0, 8'h11, 32'hAAAAAA11,  0, 0, 32'h00000000));
        vecs.push_back(mk(0, 1, 2'b00, 0, 8'h13, 32'h55555522,  0, 0, 32'h00000000));
        vecs.push_back(mk(1, 0, 2'b10, 0, 8'h10, 32'h0,         1, 0, 32'h22AD11EF));
        vecs.push_back(mk(0, 1, 2'b10, 0, 8'h20, 32'h8000FF80,  0, 0, 32'h22AD11EF));
        vecs.push_back(mk(0, 0, 2'b10, 0, 8'h20, 32'h0,         0, 0, 32'h22AD11EF));
        vecs.push_back(mk(1, 0, 2'b00, 0, 8'h20, 32'h0,         1, 0, 32'hFFFFFF80));
        vecs.push_back(mk(1, 0, 2'b00, 1, 8'h20, 32'h0,         1, 0, 32'h00000080));
        vecs.push_back(mk(1, 0, 2'b01, 0, 8'h22, 32'h0,         1, 0, 32'hFFFF8000));
        vecs.push_back(mk(1, 0, 2'b01, 1, 8'h22, 32'h0,         1, 0, 32'h00008000));
        vecs.push_back(mk(1, 0, 2'b00, 0, 8'h21, 32'h0,         1, 0, 32'hFFFFFFFF));
        vecs.push_back(mk(1, 0, 2'b00, 1, 8'h23, 32'h0,         1, 0, 32'h00000080));
        vecs.push_back(mk(1, 0, 2'b01, 1, 8'h20, 32'h0,         1, 0, 32'h0000FF80));
        vecs.push_back(mk(1, 0, 2'b01, 0, 8'h20, 32'h0,         1, 0, 32'hFFFFFF80));
        vecs.push_back(mk(0, 1, 2'b01, 0, 8'h21, 32'h00001234,  0, 1, 32'hFFFFFF80));
        vecs.push_back(mk(1, 0, 2'b10, 0, 8'h22, 32'h0,         0, 1, 32'hFFFFFF80));
        vecs.push_back(mk(1, 0, 2'b10, 0, 8'h20, 32'h0,         1, 0, 32'h8000FF80));
        vecs.push_back(mk(1, 0, 2'b11, 0, 8'h20, 32'h0,         0, 1, 32'h8000FF80));
        vecs.push_back(mk(0, 1, 2'b11, 0, 8'h20, 32'h0,         0, 1, 32'h8000FF80));
        vecs.push_back(mk(1, 0, 2'b10, 0, 8'h20, 32'h0,         1, 0, 32'h8000FF80));
        vecs.push_back(mk(0, 1, 2'b01, 0, 8'h26, 32'hFFFFCAFE,  0, 0, 32'h8000FF80));
        vecs.push_back(mk(1, 0, 2'b10, 0, 8'h24, 32'h0,         1, 0, 32'hCAFE0000));
        vecs.push_back(mk(1, 0, 2'b01, 0, 8'h26, 32'h0,         1, 0, 32'hFFFFCAFE));
        vecs.push_back(mk(0, 1, 2'b10, 0, 8'h30, 32'h12345678,  0, 0, 32'hFFFFCAFE));
        vecs.push_back(mk(1, 1, 2'b10, 0, 8'h30, 32'hCAFEF00D,  1, 0, FWD_W));
        vecs.push_back(mk(1, 0, 2'b10, 0, 8'h30, 32'h0,         1, 0, 32'hCAFEF00D));
        vecs.push_back(mk(1, 1, 2'b00, 1, 8'h31, 32'h000000AB,  1, 0, FWD_B));
        vecs.push_back(mk(1, 0, 2'b10, 0, 8'h30, 32'h0,         1, 0, 32'hCAFEAB0D));

        foreach (vecs[i]) begin
            MemoryRead = vecs[i].rd; MemoryWrite = vecs[i].wr; Size = vecs[i].size;
            Unsigned = vecs[i].uns; Address = vecs[i].addr; WriteData = vecs[i].wdata;
            @(negedge Clock);
            check($sformatf("vec%0d ReadValid", i), {31'b0, ReadValid}, {31'b0, vecs[i].exp_v});
            check($sformatf("vec%0d Misaligned", i), {31'b0, Misaligned}, {31'b0, vecs[i].exp_m});
            check($sformatf("vec%0d ReadData", i), ReadData, vecs[i].exp_d);
        end
        idle_inputs();
        @(negedge Clock);
        check("idle ReadValid", {31'b0, ReadValid}, 32'd0);
        check("idle ReadData hold", ReadData, 32'hCAFEAB0D);

        // Reset, then reset again 30 cycles into the sweep
        Reset_n = 1'b0;
        repeat (2) @(negedge Clock);
        Reset_n = 1'b1;
        repeat (30) @(negedge Clock);
        check("mid-sweep Busy", {31'b0, Busy}, 32'd1);
        Reset_n = 1'b0;
        repeat (2) @(negedge Clock);
        Reset_n = 1'b1;
        // Hammer word 0 with stores and loads while busy; all must be dropped
        MemoryRead = 1'b1; MemoryWrite = 1'b1; Size = 2'b10; Address = 8'h00;
        WriteData = 32'hFFFFFFFF;
        count_busy("sweep2", 1'b1);
        idle_inputs();
        check("post-sweep valid", {31'b0, ReadValid}, 32'd0);
        check("post-sweep ReadData", ReadData, 32'd0);

        // Back-to-back loads of every word
        for (int w = 0; w < 64; w++) begin
            MemoryRead = 1'b1; Size = 2'b10; Address = 8'(w * 4);
            @(negedge Clock);
            check($sformatf("clear w%0d valid", w), {31'b0, ReadValid}, 32'd1);
            check($sformatf("clear w%0d data", w), ReadData, 32'd0);
        end
        idle_inputs();
        @(negedge Clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
